// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing sets and width helper.
//   Provides 640x480@60 and 800x600@60 constants plus clog2w(), a $clog2 that
//   never returns zero so every derived bus is at least one bit wide.
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam bit VGA_HS_POL = 1'b0;
  localparam bit VGA_VS_POL = 1'b0;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP = 40;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BP = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP = 1;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BP = 23;
  localparam bit SVGA_HS_POL = 1'b1;
  localparam bit SVGA_VS_POL = 1'b1;
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with one image window.
//   clk, rst_n (async active-low), en (count enable), win_x0/win_y0 (requested
//   window origin, taken at frame end). Outputs, all one register stage after the
//   counters: hsync, vsync, de, x, y, line_start, frame_start, win_active,
//   win_x, win_y, win_done.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit HS_POL = VGA_HS_POL,
  parameter bit VS_POL = VGA_VS_POL,
  parameter int WIN_W = 64,
  parameter int WIN_H = 64,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW = clog2w(H_TOTAL),
  localparam int YW = clog2w(V_TOTAL),
  localparam int WXW = clog2w(WIN_W),
  localparam int WYW = clog2w(WIN_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [XW-1:0]  win_x0,
  input  logic [YW-1:0]  win_y0,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic           win_active,
  output logic [WXW-1:0] win_x,
  output logic [WYW-1:0] win_y,
  output logic           win_done
);
  logic [XW-1:0] hcnt, ox;
  logic [YW-1:0] vcnt, oy;
  logic [XW:0] hx, x0, x1, xe;
  logic [YW:0] vy, y0, y1, ye;
  logic h_end, v_end, act, hs_on, vs_on, in_win, last;
  logic ls_q, fs_q, wd_q;
  // One extra bit on the window bounds so origin + size cannot wrap.
  always_comb begin
    hx = {1'b0, hcnt};
    vy = {1'b0, vcnt};
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    x1 = x0 + (XW+1)'(WIN_W);
    y1 = y0 + (YW+1)'(WIN_H);
    xe = (x1 > (XW+1)'(H_ACTIVE)) ? (XW+1)'(H_ACTIVE - 1) : x1 - (XW+1)'(1);
    ye = (y1 > (YW+1)'(V_ACTIVE)) ? (YW+1)'(V_ACTIVE - 1) : y1 - (YW+1)'(1);
    h_end = hcnt == XW'(H_TOTAL - 1);
    v_end = vcnt == YW'(V_TOTAL - 1);
    act = (hcnt < XW'(H_ACTIVE)) && (vcnt < YW'(V_ACTIVE));
    hs_on = (hx >= (XW+1)'(H_ACTIVE + H_FP)) && (hx < (XW+1)'(H_ACTIVE + H_FP + H_SYNC));
    vs_on = (vy >= (YW+1)'(V_ACTIVE + V_FP)) && (vy < (YW+1)'(V_ACTIVE + V_FP + V_SYNC));
    in_win = act && (hx >= x0) && (hx < x1) && (vy >= y0) && (vy < y1);
    // Clipped bottom-right corner; never reached when the window is off-screen.
    last = in_win && (hx == xe) && (vy == ye);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      ox <= '0;
      oy <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      wd_q <= 1'b0;
      win_active <= 1'b0;
      win_x <= '0;
      win_y <= '0;
    end else if (en) begin
      hcnt <= h_end ? '0 : hcnt + XW'(1);
      if (h_end) vcnt <= v_end ? '0 : vcnt + YW'(1);
      if (h_end && v_end) begin
        ox <= win_x0;
        oy <= win_y0;
      end
      hsync <= hs_on ^ ~HS_POL;
      vsync <= vs_on ^ ~VS_POL;
      de <= act;
      x <= hcnt;
      y <= vcnt;
      ls_q <= hcnt == '0;
      fs_q <= (hcnt == '0) && (vcnt == '0);
      wd_q <= last;
      win_active <= in_win;
      win_x <= in_win ? WXW'(hx - x0) : '0;
      win_y <= in_win ? WYW'(vy - y0) : '0;
    end
  end
  // Strobe registers hold through a stall; masking with en keeps a consumer
  // from seeing the same strobe on every frozen cycle.
  assign line_start = ls_q & en;
  assign frame_start = fs_q & en;
  assign win_done = wd_q & en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [4:0] win_x0, win_y0, x, y;
  logic hsync, vsync, de, line_start, frame_start, win_active, win_done;
  logic [1:0] win_x, win_y;
  int tests = 0, fails = 0, frames = 0;
  bit mon_on = 1'b0;
  typedef struct { int kind; int f[9]; } evt_t;
  evt_t exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .WIN_W(4), .WIN_H(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .win_x0(win_x0), .win_y0(win_y0),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .win_active(win_active),
    .win_x(win_x), .win_y(win_y), .win_done(win_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic evt_t mk(input int k, input int a, input int b, input int c, input int d,
                              input int e, input int g, input int h, input int i, input int j);
    evt_t v;
    v.kind = k;
    v.f = '{a, b, c, d, e, g, h, i, j};
    return v;
  endfunction

  // kind 1: first window pixel (x, y, win_x, win_y); kind 2: win_done pixel;
  // kind 0: frame totals (clocks, de, window, hsync-low, vsync-low, line_start,
  // first hsync-low x, first vsync-low y, nonzero win_x/win_y outside window).
  task automatic push_win(input int fx, input int fy, input int lx, input int ly,
                          input int lwx, input int lwy, input int cnt);
    exp_q.push_back(mk(1, fx, fy, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, lx, ly, lwx, lwy, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, HT*VT, HA*VA, cnt, HS*VT, VS*HT, VT, HA+HF, VA+VF, 0));
  endtask

  task automatic check_evt(input evt_t o);
    evt_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: got kind %0d expected none", o.kind);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", o.kind, e.kind);
      for (int i = 0; i < 9; i++) chk($sformatf("event %0d field %0d", e.kind, i), o.f[i], e.f[i]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " hsync"}, int'(hsync), 1);
    chk({tag, " vsync"}, int'(vsync), 1);
    chk({tag, " de"}, int'(de), 0);
    chk({tag, " x"}, int'(x), 0);
    chk({tag, " y"}, int'(y), 0);
    chk({tag, " strobes"}, int'({line_start, frame_start, win_done}), 0);
    chk({tag, " win_active"}, int'(win_active), 0);
    chk({tag, " win_xy"}, int'({win_x, win_y}), 0);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && frames < n; i++) @(negedge clk);
    if (frames < n) chk("wait for frame", frames, n);
  endtask

  task automatic wait_xy(input int wx, input int wy);
    bit hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      hit = (wx < 0 || int'(x) == wx) && int'(y) == wy;
    end
    if (!hit) chk("wait for position", int'(y), wy);
  endtask

  // Monitor: samples just after each enabled edge and raises observed events.
  initial begin
    int a_clk, a_de, a_win, a_hs, a_vs, a_ls, hs_first, vs_first, zerr;
    bit started = 1'b0, seen_win = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on && rst_n && en) begin
        if (frame_start) begin
          if (started) check_evt(mk(0, a_clk, a_de, a_win, a_hs, a_vs, a_ls, hs_first, vs_first, zerr));
          started = 1'b1;
          frames++;
          {a_clk, a_de, a_win, a_hs, a_vs, a_ls, zerr} = '{default: 0};
          hs_first = -1;
          vs_first = -1;
          seen_win = 1'b0;
        end
        if (started) begin
          a_clk++;
          if (de) a_de++;
          if (win_active) a_win++;
          if (!hsync) a_hs++;
          if (!vsync) a_vs++;
          if (line_start) a_ls++;
          if (!hsync && hs_first < 0) hs_first = int'(x);
          if (!vsync && vs_first < 0) vs_first = int'(y);
          if (!win_active && {win_x, win_y} != 4'd0) zerr++;
          if (win_active && !seen_win) begin
            seen_win = 1'b1;
            check_evt(mk(1, int'(x), int'(y), int'(win_x), int'(win_y), 0, 0, 0, 0, 0));
          end
          if (win_done) check_evt(mk(2, int'(x), int'(y), int'(win_x), int'(win_y), 0, 0, 0, 0, 0));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap;
    rst_n = 1'b0;
    en = 1'b0;
    win_x0 = '0;
    win_y0 = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    win_x0 = 5'd5;
    win_y0 = 5'd3;
    push_win(0, 0, 3, 3, 3, 3, 16);
    push_win(5, 3, 8, 6, 3, 3, 16);
    mon_on = 1'b1;
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("first x", int'(x), 0);
    chk("first y", int'(y), 0);
    chk("first de", int'(de), 1);
    chk("first frame_start", int'(frame_start), 1);
    chk("first line_start", int'(line_start), 1);
    chk("first hsync", int'(hsync), 1);
    chk("first win_active", int'(win_active), 1);
    @(negedge clk);
    chk("second x", int'(x), 1);
    chk("second strobes", int'({line_start, frame_start}), 0);
    wait_frames(2);
    wait_xy(-1, 5);
    win_x0 = 5'd9;
    push_win(9, 3, 12, 6, 3, 3, 16);
    wait_frames(3);
    wait_xy(-1, 8);
    win_x0 = 5'd14;
    win_y0 = 5'd10;
    push_win(14, 10, 15, 11, 1, 1, 4);
    wait_frames(4);
    wait_xy(-1, 12);
    win_x0 = 5'd20;
    win_y0 = 5'd0;
    exp_q.push_back(mk(0, HT*VT, HA*VA, 0, HS*VT, VS*HT, VT, HA+HF, VA+VF, 0));
    wait_frames(6);
    wait_xy(7, 4);
    en = 1'b0;
    cap = int'({hsync, vsync, de, x, y, win_active, win_x, win_y});
    chk("stall capture x", int'(x), 7);
    repeat (37) begin
      @(negedge clk);
      chk("stall hold", int'({hsync, vsync, de, x, y, win_active, win_x, win_y}), cap);
      chk("stall strobes", int'({line_start, frame_start, win_done}), 0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume x", int'(x), 8);
    chk("resume y", int'(y), 4);
    repeat (5) @(negedge clk);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    @(negedge clk);
    chk_reset("held reset");
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
